// File: rtl/pi_lane_permuter.sv
// pi_lane_permuter
// In-place pi lane permutation over a 5x5 plane of LANE_W-bit lanes.
// A whole plane is loaded in one cycle. A pass then walks the single
// 24-lane orbit that starts at (1,0), carrying one held lane along. The
// pass applies either the forward map or the inverse map.
// Lane (0,0) is a fixed point of both maps, so the walk never touches it.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        synchronous reset, active low
//   load_i       in idle, capture line_in_i into storage (wins over start_i)
//   line_in_i    plane in; lane idx = 5*x+y at bits [idx*LANE_W +: LANE_W]
//   start_i      in idle, begin one permutation pass
//   inverse_i    mode sampled with start_i: 0 forward, 1 inverse
//   busy_o       high while a pass is in progress
//   done_o       one-cycle pulse after the last lane write
//   step_o       lane writes completed in the current pass (0..24)
//   plane_out_o  live view of storage, same packing as line_in_i
module pi_lane_permuter #(
   parameter int LANE_W = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  load_i,
   input  logic [25*LANE_W-1:0]  line_in_i,
   input  logic                  start_i,
   input  logic                  inverse_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [4:0]            step_o,
   output logic [25*LANE_W-1:0]  plane_out_o
);

   typedef enum logic [2:0] {
      IDLE,
      PRIME,
      READ,
      WRITE,
      DONE
   } state_e;

   // Orbit start (1,0), packed as {x,y}
   localparam logic [5:0] P0 = {3'd1, 3'd0};

   state_e                 state_q, state_d;
   logic [25*LANE_W-1:0]   plane_q, plane_d;
   logic [LANE_W-1:0]      t_q, t_d;
   logic [LANE_W-1:0]      r_q, r_d;
   logic [5:0]             p_q, p_d;
   logic [4:0]             step_q, step_d;
   logic                   mode_q, mode_d;

   // Reduction of 0..20 modulo 5, written out as a table so no
   // divider is inferred and no intermediate bits go unused
   function automatic logic [2:0] modFive(input logic [4:0] s);
      logic [2:0] m;
      case (s)
         5'd0,  5'd5,  5'd10, 5'd15, 5'd20: m = 3'd0;
         5'd1,  5'd6,  5'd11, 5'd16:        m = 3'd1;
         5'd2,  5'd7,  5'd12, 5'd17:        m = 3'd2;
         5'd3,  5'd8,  5'd13, 5'd18:        m = 3'd3;
         5'd4,  5'd9,  5'd14, 5'd19:        m = 3'd4;
         default:                           m = 3'd0;
      endcase
      return m;
   endfunction

   // Next orbit position: forward (y, 2x+3y), inverse (x+3y, x), mod 5
   function automatic logic [5:0] mapPos(input logic inv, input logic [5:0] pos);
      logic [4:0] x5;
      logic [4:0] y5;
      logic [5:0] nxt;
      x5 = {2'b00, pos[5:3]};
      y5 = {2'b00, pos[2:0]};
      if (inv) begin
         nxt = {modFive(x5 + 5'd3 * y5), pos[5:3]};
      end else begin
         nxt = {pos[2:0], modFive(5'd2 * x5 + 5'd3 * y5)};
      end
      return nxt;
   endfunction

   // Bit offset of a lane in the flat plane
   function automatic int laneBase(input logic [5:0] pos);
      return (5 * int'(pos[5:3]) + int'(pos[2:0])) * LANE_W;
   endfunction

   // Next-state and datapath control. Storage sees at most one access per
   // cycle: PRIME and READ read it, WRITE writes it, IDLE may bulk-load it.
   always_comb begin
      state_d = state_q;
      plane_d = plane_q;
      t_d     = t_q;
      r_d     = r_q;
      p_d     = p_q;
      step_d  = step_q;
      mode_d  = mode_q;
      case (state_q)
         IDLE: begin
            if (load_i) begin
               plane_d = line_in_i;
            end else if (start_i) begin
               mode_d  = inverse_i;
               state_d = PRIME;
            end
         end
         PRIME: begin
            t_d     = plane_q[laneBase(P0) +: LANE_W];
            p_d     = mapPos(mode_q, P0);
            step_d  = 5'd0;
            state_d = READ;
         end
         READ: begin
            r_d     = plane_q[laneBase(p_q) +: LANE_W];
            state_d = WRITE;
         end
         WRITE: begin
            plane_d[laneBase(p_q) +: LANE_W] = t_q;
            t_d     = r_q;
            step_d  = step_q + 5'd1;
            p_d     = mapPos(mode_q, p_q);
            state_d = (step_q == 5'd23) ? DONE : READ;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset clears storage too, so an
   // interrupted pass leaves nothing behind
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         plane_q <= '0;
         t_q     <= '0;
         r_q     <= '0;
         p_q     <= '0;
         step_q  <= '0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         plane_q <= plane_d;
         t_q     <= t_d;
         r_q     <= r_d;
         p_q     <= p_d;
         step_q  <= step_d;
         mode_q  <= mode_d;
      end
   end

   assign busy_o      = (state_q == PRIME) || (state_q == READ) || (state_q == WRITE);
   assign done_o      = (state_q == DONE);
   assign step_o      = step_q;
   assign plane_out_o = plane_q;

endmodule

// File: doc/pi_lane_permuter.md
# pi_lane_permuter

Parametrised in-place lane-permutation engine for a 5x5 state plane with LANE_W-bit lanes. It generalises the single-bit coordinate-walking datapath to W-bit lanes and adds a forward/inverse mode and a start/busy/done handshake. The block sits between the plane loader and the next round stage: it loads a full plane, applies the pi lane permutation (or its inverse) by walking the 24-element orbit with one held lane, and exposes the result on a flat output bus.

## Interface
- LANE_W, default 1: bits per lane; plane width is 25*LANE_W.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset.
- load  input  1  when idle, captures line_in into storage.
- line_in  input  25*LANE_W  plane in; lane at index idx occupies bits [idx*LANE_W +: LANE_W].
- start  input  1  when idle, begins one permutation pass.
- inverse  input  1  mode, sampled with start; 0 = forward pi, 1 = inverse pi.
- busy  output  1  high while a pass is in progress.
- done  output  1  one-cycle pulse when a pass completes.
- step  output  5  count of completed lane writes in the current pass, 0..24.
- plane_out  output  25*LANE_W  live view of storage, same packing as line_in.

## Operation
- Coordinates: x,y in 0..4; idx = 5*x + y.
- Forward map f(x,y) = (y, (2x+3y) mod 5); result satisfies B[f(p)] = A[p].
- Inverse map g(x,y) = ((x+3y) mod 5, x); result satisfies B[g(p)] = A[p].
- Lane (0,0), idx 0, is a fixed point of both maps and is never read or written.
- Every other lane lies on a single 24-cycle orbit from p0 = (1,0), idx 5. The walk is p(k+1) = map(p(k)), and p24 = p0.
- Mode is latched at start. Changing inverse mid-pass has no effect.
- Datapath: position register P (x,y, 3 bits each), hold register T (LANE_W), read register R (LANE_W), step counter (5 bits). Storage is accessed once per cycle: one read or one write, never both.
- FSM states:
  - IDLE: load=1 writes line_in to all 25 lanes. Otherwise, start=1 -> PRIME and latches the mode. If load and start are both high, load wins and start is ignored.
  - PRIME: T <= lane[p0]; P <= map(p0); step <= 0; -> READ.
  - READ: R <= lane[P]; -> WRITE.
  - WRITE: lane[P] <= T; T <= R; step <= step+1; P <= map(P). If step was 23 -> DONE, else -> READ.
  - DONE: done=1 for this cycle; -> IDLE.
- load and start are ignored in PRIME, READ, WRITE and DONE. They are not queued.
- plane_out is meaningful only when busy=0. During a pass it shows intermediate contents.

## Timing
- Reset (rst=0 at a rising edge): storage all zero, T=R=0, P=(0,0), step=0, busy=0, done=0, state IDLE, mode forward.
  - Reset takes effect at the next edge regardless of state.
  - A pass interrupted by reset is abandoned and storage is cleared; no done pulse is produced.
- Load: line_in sampled at edge E; plane_out reflects it after E.
- Start: start sampled at edge E0. busy=1 from E0 through the edge that ends the 24th WRITE (1 PRIME + 24x(READ+WRITE) = 49 cycles).
  - done=1 in the following cycle (cycle 50 after E0) with busy=0.
  - Back to IDLE one cycle later. The earliest next start is accepted at the edge that ends DONE+1, i.e. 51 cycles after E0.
- step increments at each WRITE edge. It reads 24 during DONE and is cleared at the next PRIME.
- Widths: the mod-5 arithmetic on x,y is exact (operands 0..4, intermediate at most 20 before reduction). No LANE_W-dependent arithmetic; lanes are moved opaquely.

## Test plan
- LANE_W=1, load one-hot at idx 5 ((1,0)), start with inverse=0. Required: after 49 busy cycles, done pulses once and plane_out is one-hot at idx 2 ((0,2)); step=24 during done.
- Same load with inverse=1. Required: plane_out one-hot at idx 6 ((1,1)).
- LANE_W=8, load lane[idx]=idx (lane 0 = 0xA5), forward pass then inverse pass. Required: the intermediate lane at idx 2 = 5, idx 0 stays 0xA5 throughout, and the final plane equals the loaded plane.
- During a pass: pulse start, and separately pulse load with line_in all ones. Required: both ignored, pass result is unchanged, and exactly one done pulse occurs 50 cycles after the original start.
- Assert rst=0 at step 10 of a pass. Required: the next cycle shows busy=0, done=0, step=0, plane_out all zero, and no done pulse ever appears. A subsequent load+start completes normally.
- In IDLE, assert load and start in the same cycle. Required: plane loaded, busy stays 0, no pass starts.
